// File: rtl/shift_issue_sched.sv
// rtl/shift_issue_sched.sv - round-robin issue of NREQ slots onto one pipelined shift datapath

// Shift datapath: recognised ops carry major 8'h5A in [7:0], funct in [11:8], zero in [39:12].
// Any other encoding, or funct outside 1..5, produces res=0 and ov=0.
module shift_dp #(
  parameter int WID = 80
) (
  input  logic [39:0]    instr_i,
  input  logic [WID-1:0] a_i,
  input  logic [6:0]     b_i,
  output logic [WID-1:0] res_o,
  output logic           ov_o
);
  localparam logic [7:0] SHIFT_MAJ = 8'h5A;
  localparam logic [3:0] F_SHL = 4'd1;
  localparam logic [3:0] F_SHR = 4'd2;
  localparam logic [3:0] F_ASR = 4'd3;
  localparam logic [3:0] F_ROL = 4'd4;
  localparam logic [3:0] F_ROR = 4'd5;

  logic [6:0]     rot;
  logic [WID-1:0] shl;

  // Decode and compute; SHL overflow means the value no longer fits as a signed WID-bit number
  always_comb begin
    res_o = '0;
    ov_o  = 1'b0;
    rot   = 7'(int'(b_i) % WID);
    shl   = a_i << b_i;
    if (instr_i[7:0] == SHIFT_MAJ && instr_i[39:12] == '0) begin
      case (instr_i[11:8])
        F_SHL: begin
          res_o = shl;
          ov_o  = ($signed(shl) >>> b_i) != $signed(a_i);
        end
        F_SHR: res_o = a_i >> b_i;
        F_ASR: res_o = $signed(a_i) >>> b_i;
        F_ROL: res_o = (a_i << rot) | (a_i >> (7'(WID) - rot));
        F_ROR: res_o = (a_i >> rot) | (a_i << (7'(WID) - rot));
        default: begin
          res_o = '0;
          ov_o  = 1'b0;
        end
      endcase
    end
  end
endmodule

module shift_issue_sched #(
  parameter int NREQ = 2,
  parameter int WID  = 80,
  parameter int RIDW = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*40-1:0]   instr_i,
  input  logic [NREQ*WID-1:0]  a_i,
  input  logic [NREQ*7-1:0]    b_i,
  input  logic [NREQ*RIDW-1:0] rid_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [WID-1:0]       res_o,
  output logic                 ov_o,
  output logic [RIDW-1:0]      res_rid_o,
  output logic                 busy_o
);
  localparam int PW = (NREQ > 2) ? 2 : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            s1_v_q, s1_v_d;
  logic [39:0]     s1_instr_q, s1_instr_d;
  logic [WID-1:0]  s1_a_q, s1_a_d;
  logic [6:0]      s1_b_q, s1_b_d;
  logic [RIDW-1:0] s1_rid_q, s1_rid_d;
  logic            s2_v_q, s2_v_d;
  logic [WID-1:0]  s2_res_q, s2_res_d;
  logic            s2_ov_q, s2_ov_d;
  logic [RIDW-1:0] s2_rid_q, s2_rid_d;

  logic            adv1, adv2;
  logic            found;
  logic [PW-1:0]   idx, gidx;
  logic [NREQ-1:0] gnt;
  logic [WID-1:0]  dp_res;
  logic            dp_ov;

  shift_dp #(.WID(WID)) u_dp (
    .instr_i (s1_instr_q),
    .a_i     (s1_a_q),
    .b_i     (s1_b_q),
    .res_o   (dp_res),
    .ov_o    (dp_ov)
  );

  assign adv2 = !s2_v_q || res_ready_i;
  assign adv1 = !s1_v_q || adv2;

  // Round-robin grant: first requester at or after the pointer, only when stage 1 can take it
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    gidx  = '0;
    if (rst_ni && adv1 && !flush_i) begin
      for (int i = 0; i < NREQ; i++) begin
        idx = PW'((int'(ptr_q) + i) % NREQ);
        if (!found && req_i[idx]) begin
          found     = 1'b1;
          gidx      = idx;
          gnt[idx]  = 1'b1;
          ptr_d     = PW'((int'(idx) + 1) % NREQ);
        end
      end
    end
  end

  // Stage 1 operand register: load on grant, drain to a bubble when it advances empty-handed
  always_comb begin
    s1_v_d     = s1_v_q;
    s1_instr_d = s1_instr_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_rid_d   = s1_rid_q;
    if (flush_i) begin
      s1_v_d = 1'b0;
    end else if (adv1) begin
      s1_v_d = found;
      if (found) begin
        s1_instr_d = instr_i[int'(gidx)*40 +: 40];
        s1_a_d     = a_i[int'(gidx)*WID +: WID];
        s1_b_d     = b_i[int'(gidx)*7 +: 7];
        s1_rid_d   = rid_i[int'(gidx)*RIDW +: RIDW];
      end
    end
  end

  // Stage 2 result register: holds while the result bus stalls
  always_comb begin
    s2_v_d   = s2_v_q;
    s2_res_d = s2_res_q;
    s2_ov_d  = s2_ov_q;
    s2_rid_d = s2_rid_q;
    if (flush_i) begin
      s2_v_d = 1'b0;
    end else if (adv2) begin
      s2_v_d   = s1_v_q;
      s2_res_d = dp_res;
      s2_ov_d  = dp_ov;
      s2_rid_d = s1_rid_q;
    end
  end

  // State registers; reset wins over flush
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      s1_v_q     <= 1'b0;
      s1_instr_q <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_rid_q   <= '0;
      s2_v_q     <= 1'b0;
      s2_res_q   <= '0;
      s2_ov_q    <= 1'b0;
      s2_rid_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_v_q     <= s1_v_d;
      s1_instr_q <= s1_instr_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_rid_q   <= s1_rid_d;
      s2_v_q     <= s2_v_d;
      s2_res_q   <= s2_res_d;
      s2_ov_q    <= s2_ov_d;
      s2_rid_q   <= s2_rid_d;
    end
  end

  assign gnt_o       = gnt;
  assign res_valid_o = s2_v_q;
  assign res_o       = s2_res_q;
  assign ov_o        = s2_ov_q;
  assign res_rid_o   = s2_rid_q;
  assign busy_o      = s1_v_q || s2_v_q;
endmodule

// File: tb/tb_shift_issue_sched.sv
// tb/tb_shift_issue_sched.sv - randomized scoreboard bench for shift_issue_sched
module tb_shift_issue_sched;
  logic         clk = 1'b0;
  logic         rst_ni, flush_i, res_ready_i;
  logic [1:0]   req_i, gnt_o;
  logic [79:0]  instr_i_unused_pad;
  logic [79:0]  res_o;
  logic         res_valid_o, ov_o, busy_o;
  logic [4:0]   res_rid_o;
  logic [39:0]  ins [2];
  logic [79:0]  av  [2];
  logic [6:0]   bv  [2];
  logic [4:0]   rv  [2];

  typedef struct { logic [79:0] res; logic ov; logic [4:0] rid; } exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0;
  int mptr = 0;
  bit ms1 = 0, ms2 = 0;

  always #5 clk = ~clk;

  shift_issue_sched #(.NREQ(2), .WID(80), .RIDW(5)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .req_i(req_i),
    .instr_i({ins[1], ins[0]}), .a_i({av[1], av[0]}), .b_i({bv[1], bv[0]}),
    .rid_i({rv[1], rv[0]}), .gnt_o(gnt_o), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i), .res_o(res_o), .ov_o(ov_o),
    .res_rid_o(res_rid_o), .busy_o(busy_o)
  );

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference shifter written bit by bit from the operation definitions
  function automatic void ref_op(input logic [39:0] in, input logic [79:0] a,
                                 input logic [6:0] bb, output logic [79:0] r, output logic ov);
    int b, rr;
    b = int'(bb);
    rr = b % 80;
    r = '0;
    ov = 1'b0;
    if (in[7:0] != 8'h5A || in[39:12] != 28'd0) return;
    case (in[11:8])
      4'd1: begin
        for (int i = 0; i < 80; i++) if (i >= b) r[i] = a[i-b];
        if (a != 0) begin
          if (b >= 80) ov = 1'b1;
          else for (int i = 79 - b; i < 79; i++) if (a[i] != a[79]) ov = 1'b1;
        end
      end
      4'd2: for (int i = 0; i < 80; i++) r[i] = (i + b < 80) ? a[i+b] : 1'b0;
      4'd3: for (int i = 0; i < 80; i++) r[i] = (i + b < 80) ? a[i+b] : a[79];
      4'd4: for (int i = 0; i < 80; i++) r[(i+rr)%80] = a[i];
      4'd5: for (int i = 0; i < 80; i++) r[i] = a[(i+rr)%80];
      default: ;
    endcase
  endfunction

  function automatic logic [39:0] mk_ins(input logic [3:0] f);
    logic [39:0] v;
    v = '0;
    v[7:0] = 8'h5A;
    v[11:8] = f;
    return v;
  endfunction

  task automatic set_slot(input int s, input logic [3:0] f, input logic [79:0] a,
                          input logic [6:0] b, input logic [4:0] rid);
    ins[s] = mk_ins(f); av[s] = a; bv[s] = b; rv[s] = rid;
  endtask

  task automatic rand_slot(input int s);
    int sel;
    sel = $urandom_range(0, 11);
    ins[s] = mk_ins(4'($urandom_range(1, 5)));
    if (sel == 8) ins[s][11:8] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(6, 15));
    if (sel == 9) ins[s][7:0] = 8'h5B;
    if (sel == 10) ins[s][39:12] = 28'($urandom_range(1, 1000));
    case ($urandom_range(0, 5))
      0: av[s] = '0;
      1: av[s] = '1;
      2: av[s] = 80'($urandom_range(0, 255));
      default: av[s] = 80'({$urandom(), $urandom(), $urandom()});
    endcase
    bv[s] = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(80, 127)) : 7'($urandom_range(0, 79));
    rv[s] = 5'($urandom_range(0, 31));
  endtask

  // One clock cycle: apply inputs, predict and check grant/valid/busy, then advance the model
  task automatic step(input logic [1:0] rq, input logic rdy, input logic fl, input logic rn);
    logic [1:0] eg;
    int k;
    bit a1, a2;
    exp_t e;
    req_i = rq; res_ready_i = rdy; flush_i = fl; rst_ni = rn;
    #1;
    a2 = !ms2 || rdy;
    a1 = !ms1 || a2;
    eg = '0;
    k = -1;
    if (rn && !fl && a1)
      for (int i = 0; i < 2; i++) if (k < 0 && rq[(mptr+i)%2]) k = (mptr + i) % 2;
    if (k >= 0) eg[k] = 1'b1;
    chk("gnt", 80'(gnt_o), 80'(eg));
    chk("res_valid", 80'(res_valid_o), 80'(ms2));
    chk("busy", 80'(busy_o), 80'(ms1 || ms2));
    if (k >= 0) begin
      ref_op(ins[k], av[k], bv[k], e.res, e.ov);
      e.rid = rv[k];
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (!rn) begin
      ms1 = 0; ms2 = 0; mptr = 0; exp_q.delete();
    end else if (fl) begin
      ms1 = 0; ms2 = 0; exp_q.delete();
    end else begin
      if (a2) ms2 = ms1;
      if (a1) ms1 = (k >= 0);
      if (k >= 0) mptr = (k + 1) % 2;
    end
    @(negedge clk);
  endtask

  // Monitor: every presented result must match the oldest outstanding op; pop on delivery
  always @(negedge clk) begin
    #2;
    if (rst_ni === 1'b1 && res_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: got rid %h with nothing outstanding at %0t", res_rid_o, $time);
      end else begin
        chk("res", res_o, exp_q[0].res);
        chk("ov", 80'(ov_o), 80'(exp_q[0].ov));
        chk("rid", 80'(res_rid_o), 80'(exp_q[0].rid));
        if (res_ready_i && !flush_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    instr_i_unused_pad = '0;
    for (int s = 0; s < 2; s++) set_slot(s, 4'd0, '0, '0, '0);
    req_i = 2'b11; res_ready_i = 1'b1; flush_i = 1'b0; rst_ni = 1'b0;
    @(posedge clk);
    @(negedge clk);
    step(2'b11, 1'b1, 1'b0, 1'b0);
    step(2'b11, 1'b1, 1'b0, 1'b0);
    chk("reset_res", res_o, '0);
    chk("reset_ov", 80'(ov_o), '0);
    chk("reset_rid", 80'(res_rid_o), '0);

    // First grant after reset goes to slot 0: SHL 1 by 79
    set_slot(0, 4'd1, 80'd1, 7'd79, 5'd7);
    step(2'b11, 1'b1, 1'b0, 1'b1);
    step(2'b00, 1'b1, 1'b0, 1'b1);
    chk("shl_valid", 80'(res_valid_o), 80'd1);
    chk("shl_res", res_o, 80'h8000_0000_0000_0000_0000);
    chk("shl_ov", 80'(ov_o), 80'd1);
    chk("shl_rid", 80'(res_rid_o), 80'd7);
    step(2'b00, 1'b1, 1'b0, 1'b1);

    // ASR keeps the sign
    set_slot(1, 4'd3, 80'h8000_0000_0000_0000_0000, 7'd4, 5'd3);
    step(2'b10, 1'b1, 1'b0, 1'b1);
    step(2'b00, 1'b1, 1'b0, 1'b1);
    chk("asr_res", res_o, 80'hF800_0000_0000_0000_0000);
    step(2'b00, 1'b1, 1'b0, 1'b1);

    // Round robin with both slots requesting
    for (int c = 0; c < 6; c++) begin
      rand_slot(0); rand_slot(1);
      step(2'b11, 1'b1, 1'b0, 1'b1);
    end
    // Backpressure then release
    for (int c = 0; c < 5; c++) begin
      rand_slot(0); rand_slot(1);
      step(2'b11, 1'b0, 1'b0, 1'b1);
    end
    for (int c = 0; c < 4; c++) step(2'b00, 1'b1, 1'b0, 1'b1);
    // Flush with both stages valid
    rand_slot(0); rand_slot(1);
    step(2'b11, 1'b0, 1'b0, 1'b1);
    step(2'b11, 1'b0, 1'b0, 1'b1);
    step(2'b11, 1'b1, 1'b1, 1'b1);
    step(2'b11, 1'b1, 1'b0, 1'b1);
    step(2'b00, 1'b1, 1'b0, 1'b1);
    step(2'b00, 1'b1, 1'b0, 1'b1);
    // Reset mid-stream with a stalled, full pipeline
    for (int c = 0; c < 3; c++) begin
      rand_slot(0); rand_slot(1);
      step(2'b11, 1'b0, 1'b0, 1'b1);
    end
    step(2'b11, 1'b0, 1'b0, 1'b0);
    step(2'b11, 1'b1, 1'b0, 1'b1);
    // Random traffic
    for (int c = 0; c < 600; c++) begin
      rand_slot(0); rand_slot(1);
      step(2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) != 0));
    end
    for (int c = 0; c < 5; c++) step(2'b00, 1'b1, 1'b0, 1'b1);
    chk("drained", 80'(exp_q.size()), 80'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_issue_sched.md
Name: shift_issue_sched

Overview:
- Shares the single 80-bit shift datapath between NREQ integer issue slots.
- Round-robin arbitration, two-stage pipeline (operand register, result register), backpressure from the result bus, and flush on branch miss/exception.
- Sits between the issue queues and the common data bus. The shift datapath is instantiated inside this block; its shift, rotate and overflow semantics are not altered.

Parameters:
- NREQ, 2, number of requesting issue slots (2..4).
- WID, 80, operand/result width; passed to the shift datapath.
- RIDW, 5, reorder-buffer tag width.

Ports:
- clk_i, in, 1, clock.
- rst_ni, in, 1, reset: synchronous, active-low.
- flush_i, in, 1, kill all in-flight shift ops.
- req_i, in, NREQ, slot n has a shift op ready.
- instr_i, in, NREQ*40, instruction per slot.
- a_i, in, NREQ*WID, operand A per slot.
- b_i, in, NREQ*7, shift amount per slot.
- rid_i, in, NREQ*RIDW, ROB tag per slot.
- gnt_o, in→out, NREQ, one-hot grant; the op is accepted in the same cycle.
- res_valid_o, out, 1, result valid.
- res_ready_i, in, 1, result bus accepts this cycle.
- res_o, out, WID, shift result.
- ov_o, out, 1, overflow flag from the datapath.
- res_rid_o, out, RIDW, tag of the result.
- busy_o, out, 1, either stage valid.

Behaviour:
- Reset (rst_ni=0 at a clk_i edge) clears:
  - s1_v and s2_v;
  - res_valid_o, gnt_o, busy_o;
  - res_o, ov_o, res_rid_o (all to 0);
  - the round-robin pointer (to 0).
  Reset mid-operation discards all ops; no result is emitted.
- Stage advance:
  - adv2 = !s2_v | res_ready_i.
  - adv1 = !s1_v | adv2.
- Grant is combinational.
  - When adv1 & !flush_i, grant the first requester at or after the pointer, searching cyclically upward.
  - gnt_o is one-hot or zero; it is never asserted for a non-requesting slot.
  - After a grant to slot k, the pointer becomes (k+1) mod NREQ. With no grant, the pointer holds.
- Stage 1: on grant, capture instr, a, b, rid into s1 registers and set s1_v. If adv1 occurs without a grant, clear s1_v.
- Datapath: the shift datapath is driven from the s1 registers, combinationally.
- Stage 2: on adv2, capture s2 ← {s1 result, ov, rid} and s2_v ← s1_v.
- Outputs:
  - res_valid_o = s2_v.
  - res_o, ov_o, res_rid_o come from the s2 registers.
  - They hold stable while res_valid_o & !res_ready_i.
- Latency: grant at cycle N gives res_valid_o at cycle N+2 if not stalled. Throughput is 1 op/cycle.
- Backpressure:
  - s2 full and not ready: s2 holds.
  - s1 full as well: s1 holds and no grant is issued.
  - s1 empty: one grant is still allowed (fills the bubble).
- flush_i (synchronous):
  - Clear s1_v and s2_v at the edge.
  - gnt_o is 0 in that cycle.
  - The pointer is unchanged.
  - A result presented in the flush cycle is not considered delivered even if res_ready_i=1. The consumer ignores it, because flush has priority.
- Flush has priority over reset? No: reset has priority over flush. Flush has priority over grant and over stage advance.
- A non-shift or unrecognised instruction passes through, producing the datapath's default result of 0 with ov computed as per the datapath. No trap is raised here.
- busy_o = s1_v | s2_v.

Test Plan:
- Reset behaviour: hold rst_ni=0 for 2 cycles with req_i=2'b11 → gnt_o=0, res_valid_o=0, all outputs 0. Release; the first grant goes to slot 0.
- Single shift: slot 0 issues SHL with a=1, b=79, res_ready_i=1 → at N+2, res_valid_o=1, res_o=80'h8000_0000_0000_0000_0000, ov_o=1, res_rid_o equals the issued tag.
- Round-robin fairness: req_i=2'b11 held for 6 cycles, ready=1 → grants alternate 01,10,01,10,…; results return in grant order with matching tags; ASR a=80'h8…0, b=4 → res_o=80'hF8…0.
- Backpressure: res_ready_i=0 for 5 cycles with continuous requests → exactly 2 ops accepted, then gnt_o=0. res_o and res_rid_o stay stable. Release → results drain in order with no loss or duplication.
- Flush: flush_i pulsed with both stages valid → next cycle res_valid_o=0 and busy_o=0; gnt_o=0 during the flush cycle; the pointer is unchanged on the next grant.
- Reset mid-stream: rst_ni=0 with both stages full and ready=0 → after reset the pointer is 0 and no stale result appears.
